id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised decode->execute pipeline register for the Y86 pipeline core.
//  Sits between decode and execute and captures all decode outputs on every
//  clock edge, like the plain ID/EX latch. Adds stall (hold), bubble (NOP
//  insert) and a valid bit, plus saturating stall/bubble counters and a
//  sticky control-conflict flag for the hazard unit and debug.
// PARAMETERS
//  WORD_W     32     width of valA/valB/valC/valP
//  FIELD_W    8      width of icode/ifun/register-id fields
//  NOP_ICODE  8'h1   icode injected on bubble/reset
//  RNONE      8'hF   "no register" id injected into rA/rB/dstE/dstM
//  CNT_W      16     width of stall_cnt/bubble_cnt
// PORTS
//  clk         in   1        single clock; all state updates on posedge
//  rst         in   1        synchronous reset, active-high
//  stall       in   1        hold current contents (from hazard unit)
//  bubble      in   1        load NOP instead of decode outputs
//  id_valid    in   1        decode stage holds a real instruction
//  id_icode    in   FIELD_W  decode icode
//  id_ifun     in   FIELD_W  decode ifun
//  id_rA       in   FIELD_W  decode rA
//  id_rB       in   FIELD_W  decode rB
//  id_valA     in   WORD_W   decode valA
//  id_valB     in   WORD_W   decode valB
//  id_valC     in   WORD_W   decode valC
//  id_valP     in   WORD_W   decode valP
//  id_dstE     in   FIELD_W  decode dstE
//  id_dstM     in   FIELD_W  decode dstM
//  ex_valid    out  1        execute stage holds a real instruction
//  ex_icode..ex_dstM out     registered copies of id_* (same widths)
//  stall_cnt   out  CNT_W    cycles with stall applied (saturating)
//  bubble_cnt  out  CNT_W    bubbles inserted (saturating)
//  ctl_err     out  1        sticky: stall and bubble seen together
// BEHAVIOUR
//  - One-cycle latency: id_* sampled at posedge appears on ex_* after it.
//  - Priority at each posedge: rst > stall > bubble > load.
//  - rst=1: load NOP pattern; stall_cnt=0, bubble_cnt=0, ctl_err=0.
//  - NOP pattern: ex_icode=NOP_ICODE, ex_ifun=0, ex_rA=ex_rB=ex_dstE=
//    ex_dstM=RNONE, ex_valA/B/C/P=0, ex_valid=0.
//  - stall=1: all ex_* and ex_valid hold; stall_cnt+1 unless all-ones.
//  - stall=0, bubble=1: load NOP pattern; bubble_cnt+1 unless all-ones.
//  - stall=0, bubble=0: ex_* <= id_*, ex_valid <= id_valid; counters hold.
//  - stall=1 and bubble=1 same cycle: stall wins (hold, stall_cnt+1,
//    bubble_cnt unchanged); ctl_err set to 1 and held until rst.
//  - rst during stall or bubble: reset wins; counters clear that edge.
//  - Counters saturate at {CNT_W{1'b1}}; never wrap to 0.
//  - id_valid=0 with load: fields still copied verbatim, ex_valid=0.
//  - No combinational path from any input to any output.
// TESTING
//  1 rst=1 one cycle -> ex_icode=8'h1, ex_rA=ex_dstE=ex_dstM=8'hF,
//    ex_valA=0, ex_valid=0, counters 0, ctl_err=0.
//  2 load id_icode=8'h6,id_valA=32'h12,id_valid=1, stall=bubble=0 ->
//    next cycle ex_icode=8'h6, ex_valA=32'h12, ex_valid=1.
//  3 after (2) stall=1 3 cycles with new id_* -> ex_* still 8'h6/32'h12,
//    stall_cnt=3.
//  4 bubble=1 one cycle -> ex_icode=8'h1, ex_valid=0, bubble_cnt=1; then
//    load resumes next cycle with id_* values.
//  5 stall=bubble=1 -> contents held, stall_cnt+1, bubble_cnt unchanged,
//    ctl_err=1 and stays 1 after both drop, clears only on rst.
//  6 CNT_W=2, stall 5 cycles -> stall_cnt=3 (saturated); rst -> 0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
// Decode -> execute pipeline register for the Y86 pipeline core.
// Captures every decode output on each rising clock edge. The hazard unit can
// hold the register (stall) or replace its contents with a NOP (bubble).
// Saturating stall/bubble counters and a sticky conflict flag are kept for the
// hazard unit and for debug visibility.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.

module id_ex_pipe_reg #(
    parameter int                 WORD_W    = 32,
    parameter int                 FIELD_W   = 8,
    parameter logic [FIELD_W-1:0] NOP_ICODE = 8'h1,
    parameter logic [FIELD_W-1:0] RNONE     = 8'hF,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               bubble,
    input  logic               id_valid,
    input  logic [FIELD_W-1:0] id_icode,
    input  logic [FIELD_W-1:0] id_ifun,
    input  logic [FIELD_W-1:0] id_rA,
    input  logic [FIELD_W-1:0] id_rB,
    input  logic [WORD_W-1:0]  id_valA,
    input  logic [WORD_W-1:0]  id_valB,
    input  logic [WORD_W-1:0]  id_valC,
    input  logic [WORD_W-1:0]  id_valP,
    input  logic [FIELD_W-1:0] id_dstE,
    input  logic [FIELD_W-1:0] id_dstM,
    output logic               ex_valid,
    output logic [FIELD_W-1:0] ex_icode,
    output logic [FIELD_W-1:0] ex_ifun,
    output logic [FIELD_W-1:0] ex_rA,
    output logic [FIELD_W-1:0] ex_rB,
    output logic [WORD_W-1:0]  ex_valA,
    output logic [WORD_W-1:0]  ex_valB,
    output logic [WORD_W-1:0]  ex_valC,
    output logic [WORD_W-1:0]  ex_valP,
    output logic [FIELD_W-1:0] ex_dstE,
    output logic [FIELD_W-1:0] ex_dstM,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic               ctl_err
);

    // Counters stop at all-ones instead of wrapping back to zero.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pipeline payload: reset and bubble both load the NOP pattern, stall holds, otherwise copy decode.
    always_ff @(posedge clk) begin
        if (rst || (!stall && bubble)) begin
            ex_valid <= 1'b0;
            ex_icode <= NOP_ICODE;
            ex_ifun  <= '0;
            ex_rA    <= RNONE;
            ex_rB    <= RNONE;
            ex_valA  <= '0;
            ex_valB  <= '0;
            ex_valC  <= '0;
            ex_valP  <= '0;
            ex_dstE  <= RNONE;
            ex_dstM  <= RNONE;
        end else if (!stall) begin
            ex_valid <= id_valid;
            ex_icode <= id_icode;
            ex_ifun  <= id_ifun;
            ex_rA    <= id_rA;
            ex_rB    <= id_rB;
            ex_valA  <= id_valA;
            ex_valB  <= id_valB;
            ex_valC  <= id_valC;
            ex_valP  <= id_valP;
            ex_dstE  <= id_dstE;
            ex_dstM  <= id_dstM;
        end
    end

    // Stall counter counts every edge where the hold actually took effect, including a stall that overrode a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bubble counter counts only bubbles that were really inserted, so a bubble masked by stall is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!stall && bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Sticky flag for the hazard unit asking for stall and bubble together; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_err <= 1'b0;
        end else if (stall && bubble) begin
            ctl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg
// Directed bench for id_ex_pipe_reg. A default-width instance covers reset,
// load, stall, bubble, conflict and reset priority. A second instance with
// CNT_W=2 covers counter saturation.

module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        bubble;
    logic        id_valid;
    logic [7:0]  id_icode, id_ifun, id_rA, id_rB, id_dstE, id_dstM;
    logic [31:0] id_valA, id_valB, id_valC, id_valP;

    logic        ex_valid;
    logic [7:0]  ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM;
    logic [31:0] ex_valA, ex_valB, ex_valC, ex_valP;
    logic [15:0] stall_cnt, bubble_cnt;
    logic        ctl_err;

    logic        rst2;
    logic        stall2;
    logic        bubble2;
    logic        ex_valid2;
    logic [7:0]  ex_icode2, ex_ifun2, ex_rA2, ex_rB2, ex_dstE2, ex_dstM2;
    logic [31:0] ex_valA2, ex_valB2, ex_valC2, ex_valP2;
    logic [1:0]  stall_cnt2, bubble_cnt2;
    logic        ctl_err2;

    int compared;
    int mismatched;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .id_valid(id_valid),
        .id_icode(id_icode), .id_ifun(id_ifun), .id_rA(id_rA), .id_rB(id_rB),
        .id_valA(id_valA), .id_valB(id_valB), .id_valC(id_valC), .id_valP(id_valP),
        .id_dstE(id_dstE), .id_dstM(id_dstM),
        .ex_valid(ex_valid), .ex_icode(ex_icode), .ex_ifun(ex_ifun), .ex_rA(ex_rA), .ex_rB(ex_rB),
        .ex_valA(ex_valA), .ex_valB(ex_valB), .ex_valC(ex_valC), .ex_valP(ex_valP),
        .ex_dstE(ex_dstE), .ex_dstM(ex_dstM),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_err(ctl_err)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .stall(stall2), .bubble(bubble2), .id_valid(id_valid),
        .id_icode(id_icode), .id_ifun(id_ifun), .id_rA(id_rA), .id_rB(id_rB),
        .id_valA(id_valA), .id_valB(id_valB), .id_valC(id_valC), .id_valP(id_valP),
        .id_dstE(id_dstE), .id_dstM(id_dstM),
        .ex_valid(ex_valid2), .ex_icode(ex_icode2), .ex_ifun(ex_ifun2), .ex_rA(ex_rA2), .ex_rB(ex_rB2),
        .ex_valA(ex_valA2), .ex_valB(ex_valB2), .ex_valC(ex_valC2), .ex_valP(ex_valP2),
        .ex_dstE(ex_dstE2), .ex_dstM(ex_dstM2),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2), .ctl_err(ctl_err2)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one full decode bundle; stimulus changes 1 ns after a rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] icode, input logic [7:0] ifun,
                                 input logic [7:0] ra, input logic [7:0] rb,
                                 input logic [31:0] va, input logic [31:0] vb,
                                 input logic [31:0] vc, input logic [31:0] vp,
                                 input logic [7:0] de, input logic [7:0] dm);
        id_valid = v;
        id_icode = icode; id_ifun = ifun; id_rA = ra; id_rB = rb;
        id_valA = va; id_valB = vb; id_valC = vc; id_valP = vp;
        id_dstE = de; id_dstM = dm;
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        applyStimulus(1'b1, 8'h6, 8'h2, 8'h3, 8'h4, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 8'h5, 8'h7);
        tick();
        rst = 1'b0;
        compared++;
        if ({ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM} !== {8'h1, 8'h0, 8'hF, 8'hF, 8'hF, 8'hF}) begin
            mismatched++;
            $display("[TB] FAIL reset_fields: got %h/%h/%h/%h/%h/%h expected 01/00/0f/0f/0f/0f",
                     ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM);
        end
        compared++;
        if ({ex_valA, ex_valB, ex_valC, ex_valP} !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_vals: got %h %h %h %h expected all 0", ex_valA, ex_valB, ex_valC, ex_valP);
        end
        compared++;
        if ({ex_valid, stall_cnt, bubble_cnt, ctl_err} !== {1'b0, 16'd0, 16'd0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got valid=%b stall=%0d bubble=%0d err=%b expected 0/0/0/0",
                     ex_valid, stall_cnt, bubble_cnt, ctl_err);
        end
    endtask

    task automatic test_load();
        applyStimulus(1'b1, 8'h6, 8'h2, 8'h3, 8'h4, 32'h12, 32'h34, 32'h56, 32'h78, 8'h5, 8'h7);
        tick();
        compared++;
        if ({ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM} !== {8'h6, 8'h2, 8'h3, 8'h4, 8'h5, 8'h7}) begin
            mismatched++;
            $display("[TB] FAIL load_fields: got %h/%h/%h/%h/%h/%h expected 06/02/03/04/05/07",
                     ex_icode, ex_ifun, ex_rA, ex_rB, ex_dstE, ex_dstM);
        end
        compared++;
        if ({ex_valA, ex_valB, ex_valC, ex_valP, ex_valid} !== {32'h12, 32'h34, 32'h56, 32'h78, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL load_vals: got %h %h %h %h valid=%b expected 12 34 56 78 valid=1",
                     ex_valA, ex_valB, ex_valC, ex_valP, ex_valid);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        applyStimulus(1'b1, 8'h2, 8'h0, 8'h1, 8'h1, 32'h99, 32'h98, 32'h97, 32'h96, 8'h1, 8'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            compared++;
            if ({ex_icode, ex_valA, ex_valP, ex_valid, stall_cnt} !== {8'h6, 32'h12, 32'h78, 1'b1, 16'(i)}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got icode=%h valA=%h valP=%h valid=%b cnt=%0d expected 06 12 78 1 %0d",
                         i, ex_icode, ex_valA, ex_valP, ex_valid, stall_cnt, i);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_bubble();
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        compared++;
        if ({ex_icode, ex_rA, ex_dstM, ex_valA, ex_valid} !== {8'h1, 8'hF, 8'hF, 32'h0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL bubble_nop: got icode=%h rA=%h dstM=%h valA=%h valid=%b expected 01 0f 0f 0 0",
                     ex_icode, ex_rA, ex_dstM, ex_valA, ex_valid);
        end
        compared++;
        if ({bubble_cnt, stall_cnt} !== {16'd1, 16'd3}) begin
            mismatched++;
            $display("[TB] FAIL bubble_cnt: got bubble=%0d stall=%0d expected 1 3", bubble_cnt, stall_cnt);
        end
        tick();
        compared++;
        if ({ex_icode, ex_valA, ex_valid, bubble_cnt} !== {8'h2, 32'h99, 1'b1, 16'd1}) begin
            mismatched++;
            $display("[TB] FAIL bubble_resume: got icode=%h valA=%h valid=%b bcnt=%0d expected 02 99 1 1",
                     ex_icode, ex_valA, ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_invalid_load();
        applyStimulus(1'b0, 8'h3, 8'h1, 8'h2, 8'h8, 32'hAB, 32'hCD, 32'hEF, 32'h10, 8'h9, 8'hA);
        tick();
        compared++;
        if ({ex_icode, ex_rB, ex_valA, ex_valP, ex_dstM, ex_valid} !== {8'h3, 8'h8, 32'hAB, 32'h10, 8'hA, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL invalid_load: got icode=%h rB=%h valA=%h valP=%h dstM=%h valid=%b expected 03 08 ab 10 0a 0",
                     ex_icode, ex_rB, ex_valA, ex_valP, ex_dstM, ex_valid);
        end
    endtask

    task automatic test_conflict();
        applyStimulus(1'b1, 8'h6, 8'h0, 8'h3, 8'h4, 32'h12, 32'h0, 32'h0, 32'h0, 8'h5, 8'h7);
        tick();
        stall = 1'b1; bubble = 1'b1;
        applyStimulus(1'b1, 8'hC, 8'h0, 8'h0, 8'h0, 32'h55, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
        tick();
        stall = 1'b0; bubble = 1'b0;
        compared++;
        if ({ex_icode, ex_valA, ex_valid, stall_cnt, bubble_cnt, ctl_err} !== {8'h6, 32'h12, 1'b1, 16'd4, 16'd1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL conflict_hold: got icode=%h valA=%h valid=%b scnt=%0d bcnt=%0d err=%b expected 06 12 1 4 1 1",
                     ex_icode, ex_valA, ex_valid, stall_cnt, bubble_cnt, ctl_err);
        end
        applyStimulus(1'b1, 8'h7, 8'h0, 8'h0, 8'h0, 32'h77, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
        tick();
        compared++;
        if ({ex_icode, ex_valA, stall_cnt, bubble_cnt, ctl_err} !== {8'h7, 32'h77, 16'd4, 16'd1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL conflict_sticky: got icode=%h valA=%h scnt=%0d bcnt=%0d err=%b expected 07 77 4 1 1",
                     ex_icode, ex_valA, stall_cnt, bubble_cnt, ctl_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if ({ctl_err, stall_cnt, bubble_cnt, ex_icode} !== {1'b0, 16'd0, 16'd0, 8'h1}) begin
            mismatched++;
            $display("[TB] FAIL conflict_clear: got err=%b scnt=%0d bcnt=%0d icode=%h expected 0 0 0 01",
                     ctl_err, stall_cnt, bubble_cnt, ex_icode);
        end
    endtask

    task automatic test_reset_priority();
        applyStimulus(1'b1, 8'h4, 8'h0, 8'h1, 8'h2, 32'h44, 32'h0, 32'h0, 32'h0, 8'h3, 8'h4);
        tick();
        bubble = 1'b1;
        tick();
        stall = 1'b1; bubble = 1'b0;
        tick();
        tick();
        compared++;
        if ({stall_cnt, bubble_cnt} !== {16'd2, 16'd1}) begin
            mismatched++;
            $display("[TB] FAIL prio_setup: got scnt=%0d bcnt=%0d expected 2 1", stall_cnt, bubble_cnt);
        end
        rst = 1'b1; stall = 1'b1; bubble = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;
        compared++;
        if ({stall_cnt, bubble_cnt, ctl_err, ex_icode, ex_valid} !== {16'd0, 16'd0, 1'b0, 8'h1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset_priority: got scnt=%0d bcnt=%0d err=%b icode=%h valid=%b expected 0 0 0 01 0",
                     stall_cnt, bubble_cnt, ctl_err, ex_icode, ex_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        rst2 = 1'b1; stall2 = 1'b0; bubble2 = 1'b0;
        tick();
        rst2 = 1'b0; stall2 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
            compared++;
            if (stall_cnt2 !== exp_cnt) begin
                mismatched++;
                $display("[TB] FAIL sat_stall_%0d: got %0d expected %0d", i, stall_cnt2, exp_cnt);
            end
        end
        stall2 = 1'b0; bubble2 = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        bubble2 = 1'b0;
        compared++;
        if ({bubble_cnt2, stall_cnt2} !== {2'd3, 2'd3}) begin
            mismatched++;
            $display("[TB] FAIL sat_bubble: got bcnt=%0d scnt=%0d expected 3 3", bubble_cnt2, stall_cnt2);
        end
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        compared++;
        if ({stall_cnt2, bubble_cnt2} !== {2'd0, 2'd0}) begin
            mismatched++;
            $display("[TB] FAIL sat_reset: got scnt=%0d bcnt=%0d expected 0 0", stall_cnt2, bubble_cnt2);
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        rst2 = 1'b1; stall2 = 1'b0; bubble2 = 1'b0;
        applyStimulus(1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
        #1;
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_invalid_load();
        test_conflict();
        test_reset_priority();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
